enemy_phase_scheduler: RTL and testbench
========================================

// Module: enemy_phase_scheduler
// PURPOSE
//  Sequences the enemy-row movers: generates the 2-bit phase state consumed by every row
//  mover and a one-cycle move strobe telling the enemy-position registers when to load
//  the mover output. Sits between the frame-tick generator and the enemy row datapaths.
//  Movement pattern per phase: 00/11 = +x for row 2, 01/10 = -x (row movers decode).
// PARAMETERS
//  MOVE_PERIOD      8   frame ticks between move strobes (>=2)
//  STEPS_PER_PHASE  16  move strobes per phase before phase advances (>=1)
//  FAST_THRESHOLD   8   alive count at/below which fast period applies (SPEEDUP_EN only)
// PORTS
//  i_Clk           in   1  system clock
//  i_Rst           in   1  synchronous active-high reset
//  i_FrameTick     in   1  one-cycle pulse per video frame
//  i_Start         in   1  pulse: IDLE->RUN
//  i_Pause         in   1  level: hold movement while high (RUN<->PAUSE)
//  i_Stop          in   1  pulse: abort to IDLE (game over / stage clear)
//  i_AliveCount    in   6  enemies alive (used only with SPEEDUP_EN)
//  o_PhaseState    out  2  current movement phase to row movers
//  o_MoveStrobe    out  1  one-cycle pulse: latch new enemy positions
//  o_Running       out  1  high in RUN state
//  o_CycleDone     out  1  one-cycle pulse when phase wraps 11->00
// BEHAVIOUR
//  - One clock i_Clk; reset synchronous, active-high on i_Rst. All outputs registered.
//  - Reset: state=IDLE, o_PhaseState=00, o_MoveStrobe=0, o_Running=0, o_CycleDone=0,
//    frame counter=0, step counter=0. Reset mid-operation aborts immediately, same values.
//  - FSM: IDLE --i_Start--> RUN; RUN --i_Pause--> PAUSE; PAUSE --!i_Pause--> RUN;
//    RUN/PAUSE --i_Stop--> IDLE. Priority: i_Stop > i_Pause > i_Start.
//    i_Start in RUN/PAUSE ignored. i_Start with i_Pause high in IDLE -> PAUSE.
//  - Entering IDLE (via i_Stop) clears counters and phase to 00; o_Running=0.
//  - RUN: each i_FrameTick increments frame counter; tick with counter == P-1
//    (P = effective period) -> counter<=0, o_MoveStrobe<=1 next cycle, step counter +1.
//    Compare uses >= P-1 so a shrinking period never overruns.
//  - Ticks in IDLE/PAUSE ignored; counters and phase hold in PAUSE.
//  - o_PhaseState during a strobe cycle is the phase governing that move.
//  - Strobe ending step STEPS_PER_PHASE-1: step counter->0 and phase advances
//    00->01->10->11->00 on the edge ending the strobe cycle (one cycle after strobe).
//  - Wrap 11->00 also raises o_CycleDone for that one cycle.
//  - i_Stop in the same cycle as a qualifying tick: stop wins, no strobe issued.
//  - Strobes never back-to-back: minimum spacing = P frame ticks.
//  - Counter widths: $clog2 of the respective parameter, at least 1 bit.
// CONFIGURATION
//  SPEEDUP_EN defined: P = MOVE_PERIOD/2 (min 1) when i_AliveCount <= FAST_THRESHOLD,
//    else MOVE_PERIOD; i_AliveCount sampled each tick. Change takes effect at the
//    current frame-counter value (>= compare).
//  SPEEDUP_EN undefined: P = MOVE_PERIOD constant; i_AliveCount unused.
// TESTING
//  1 Reset then 20 ticks, no i_Start -> no strobe, phase 00, o_Running=0.
//  2 i_Start, 16 ticks (P=8) -> strobes after ticks 8 and 16, phase 00 at both strobes.
//  3 Run 16 strobes -> phase 01 one cycle after 16th strobe; after 64 strobes phase 00
//    and o_CycleDone pulses once.
//  4 i_Pause high after 5 ticks for 30 ticks, then low -> next strobe after 3 more ticks.
//  5 i_Stop at step 7, phase 10 -> IDLE, phase 00, counters 0; i_Start restarts at 00.
//  6 SPEEDUP_EN, i_AliveCount=8 -> strobe every 4 ticks; =9 -> every 8 ticks;
//    switch 9->8 at frame count 5 -> strobe on the next tick.

Source files
------------

// File: rtl/enemy_phase_scheduler_if.sv
// Control and status bundle between the frame-tick/game-control side and the enemy phase scheduler.
// The slave modport is the scheduler view; master is the driver/observer view.
interface enemy_phase_scheduler_if;
  logic       i_FrameTick;
  logic       i_Start;
  logic       i_Pause;
  logic       i_Stop;
  logic [5:0] i_AliveCount;
  logic [1:0] o_PhaseState;
  logic       o_MoveStrobe;
  logic       o_Running;
  logic       o_CycleDone;

  modport slave (
    input  i_FrameTick, i_Start, i_Pause, i_Stop, i_AliveCount,
    output o_PhaseState, o_MoveStrobe, o_Running, o_CycleDone
  );

  modport master (
    output i_FrameTick, i_Start, i_Pause, i_Stop, i_AliveCount,
    input  o_PhaseState, o_MoveStrobe, o_Running, o_CycleDone
  );
endinterface

// File: rtl/enemy_phase_scheduler.sv
// Enemy movement sequencer: registered 2-bit phase, move strobe one cycle after the qualifying frame tick.
// Optional SPEEDUP_EN halves the move period when few enemies remain (alive count sampled per tick).
module enemy_phase_scheduler #(
  parameter int MOVE_PERIOD     = 8,
  parameter int STEPS_PER_PHASE = 16,
  parameter int FAST_THRESHOLD  = 8
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst,
  enemy_phase_scheduler_if.slave  bus
);

  localparam int FW          = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;
  localparam int SW          = (STEPS_PER_PHASE > 1) ? $clog2(STEPS_PER_PHASE) : 1;
  localparam int FAST_PERIOD = (MOVE_PERIOD / 2 > 0) ? MOVE_PERIOD / 2 : 1;

  localparam logic [FW-1:0] SLOW_M1 = FW'(MOVE_PERIOD - 1);
  localparam logic [FW-1:0] FAST_M1 = FW'(FAST_PERIOD - 1);
  localparam logic [SW-1:0] STEP_M1 = SW'(STEPS_PER_PHASE - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [FW-1:0] frame_q, frame_d;
  logic [SW-1:0] step_q, step_d;
  logic [1:0]    phase_q, phase_d;
  logic          adv_q, adv_d;
  logic          strobe_q, strobe_d;
  logic          running_q, running_d;
  logic          done_q, done_d;
  logic [FW-1:0] period_m1;

`ifdef SPEEDUP_EN
  always_comb begin
    period_m1 = SLOW_M1;
    if (bus.i_AliveCount <= 6'(FAST_THRESHOLD)) begin
      period_m1 = FAST_M1;
    end
  end
`else
  always_comb begin
    period_m1 = SLOW_M1;
  end
`endif

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    step_d    = step_q;
    phase_d   = phase_q;
    adv_d     = adv_q;
    strobe_d  = 1'b0;
    done_d    = 1'b0;
    running_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!bus.i_Stop && bus.i_Start) begin
          state_d = bus.i_Pause ? ST_PAUSE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.i_Stop) begin
          state_d = ST_IDLE;
        end else if (bus.i_Pause) begin
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (bus.i_Stop) begin
          state_d = ST_IDLE;
        end else if (!bus.i_Pause) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Stop wins over everything, including a tick that would have issued a strobe.
    if (bus.i_Stop) begin
      frame_d = '0;
      step_d  = '0;
      phase_d = 2'b00;
      adv_d   = 1'b0;
    end else if (state_q == ST_RUN) begin
      // Phase advance lands on the edge that ends the strobe cycle.
      if (adv_q) begin
        phase_d = phase_q + 2'd1;
        done_d  = (phase_q == 2'b11);
        adv_d   = 1'b0;
      end
      if (bus.i_FrameTick && !bus.i_Pause) begin
        // >= rather than == so a period that shrinks mid-count fires at once.
        if (frame_q >= period_m1) begin
          frame_d  = '0;
          strobe_d = 1'b1;
          if (step_q >= STEP_M1) begin
            step_d = '0;
            adv_d  = 1'b1;
          end else begin
            step_d = step_q + SW'(1);
          end
        end else begin
          frame_d = frame_q + FW'(1);
        end
      end
    end

    running_d = (state_d == ST_RUN);
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q   <= ST_IDLE;
      frame_q   <= '0;
      step_q    <= '0;
      phase_q   <= 2'b00;
      adv_q     <= 1'b0;
      strobe_q  <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      step_q    <= step_d;
      phase_q   <= phase_d;
      adv_q     <= adv_d;
      strobe_q  <= strobe_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign bus.o_PhaseState = phase_q;
  assign bus.o_MoveStrobe = strobe_q;
  assign bus.o_Running    = running_q;
  assign bus.o_CycleDone  = done_q;

endmodule

// File: tb/tb_enemy_phase_scheduler.sv
// Scoreboard bench for enemy_phase_scheduler: each expected strobe phase is queued when its tick is driven
// and popped when the strobe appears; stray strobes and never-seen strobes are both reported.
module tb_enemy_phase_scheduler;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  enemy_phase_scheduler_if bus ();

  enemy_phase_scheduler #(
    .MOVE_PERIOD    (8),
    .STEPS_PER_PHASE(16),
    .FAST_THRESHOLD (8)
  ) dut (
    .i_Clk(clk),
    .i_Rst(rst),
    .bus  (bus)
  );

  int         n_vec = 0;
  int         n_err = 0;
  int         done_cnt = 0;
  bit         prev_strobe = 1'b0;
  logic [1:0] exp_q[$];
  logic [1:0] exp_ph;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, actual still running, required finished");
    $fatal(1, "watchdog");
  end

  // One clock; outputs sampled 1 time unit after the edge, scoreboard drained here.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (bus.o_MoveStrobe === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_strobe: actual strobe=1 phase=%b, required no strobe", bus.o_PhaseState);
      end else begin
        exp_ph = exp_q.pop_front();
        if (bus.o_PhaseState !== exp_ph) begin
          n_err++;
          $display("FAIL strobe_phase: actual %b, required %b", bus.o_PhaseState, exp_ph);
        end
      end
      if (prev_strobe) begin
        n_err++;
        $display("FAIL strobe_spacing: actual back-to-back strobes, required gap");
      end
    end
    if (bus.o_CycleDone === 1'b1) done_cnt++;
    prev_strobe = (bus.o_MoveStrobe === 1'b1);
  endtask

  task automatic tick(input bit exp_strobe, input logic [1:0] ph);
    if (exp_strobe) exp_q.push_back(ph);
    bus.i_FrameTick = 1'b1;
    cyc();
    bus.i_FrameTick = 1'b0;
    cyc();
  endtask

  // Strobe k (counted from the start of a phase cycle) belongs to phase (k/16)%4.
  task automatic strobes(input int first, input int count);
    for (int k = first; k < first + count; k++) begin
      for (int t = 1; t <= 8; t++) tick(t == 8, 2'((k / 16) % 4));
    end
  endtask

  task automatic idle_ticks(input int n);
    for (int t = 0; t < n; t++) tick(1'b0, 2'b00);
  endtask

  task automatic pulse_start();
    bus.i_Start = 1'b1;
    cyc();
    bus.i_Start = 1'b0;
  endtask

  task automatic drain_check(input string name);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_missing_strobe: actual %0d strobes outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) cyc();
    n_vec++;
    if (bus.o_PhaseState !== 2'b00) begin n_err++; $display("FAIL reset_phase: actual %b, required 00", bus.o_PhaseState); end
    n_vec++;
    if (bus.o_MoveStrobe !== 1'b0) begin n_err++; $display("FAIL reset_strobe: actual %b, required 0", bus.o_MoveStrobe); end
    n_vec++;
    if (bus.o_Running !== 1'b0) begin n_err++; $display("FAIL reset_running: actual %b, required 0", bus.o_Running); end
    n_vec++;
    if (bus.o_CycleDone !== 1'b0) begin n_err++; $display("FAIL reset_done: actual %b, required 0", bus.o_CycleDone); end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_idle_ticks();
    idle_ticks(20);
    drain_check("idle");
    n_vec++;
    if (bus.o_PhaseState !== 2'b00 || bus.o_Running !== 1'b0) begin
      n_err++;
      $display("FAIL idle_state: actual phase=%b running=%b, required 00/0", bus.o_PhaseState, bus.o_Running);
    end
  endtask

  task automatic test_run();
    pulse_start();
    n_vec++;
    if (bus.o_Running !== 1'b1) begin n_err++; $display("FAIL run_running: actual %b, required 1", bus.o_Running); end
    strobes(0, 2);
    drain_check("run");
  endtask

  task automatic test_phase_advance();
    strobes(2, 14);
    drain_check("phase16");
    n_vec++;
    if (bus.o_PhaseState !== 2'b01) begin n_err++; $display("FAIL phase_after_16: actual %b, required 01", bus.o_PhaseState); end
    n_vec++;
    if (done_cnt !== 0) begin n_err++; $display("FAIL early_cycle_done: actual %0d, required 0", done_cnt); end
    strobes(16, 48);
    drain_check("phase64");
    n_vec++;
    if (bus.o_PhaseState !== 2'b00) begin n_err++; $display("FAIL phase_after_64: actual %b, required 00", bus.o_PhaseState); end
    n_vec++;
    if (done_cnt !== 1) begin n_err++; $display("FAIL cycle_done_count: actual %0d, required 1", done_cnt); end
  endtask

  task automatic test_pause();
    idle_ticks(5);
    bus.i_Pause = 1'b1;
    cyc();
    n_vec++;
    if (bus.o_Running !== 1'b0) begin n_err++; $display("FAIL pause_running: actual %b, required 0", bus.o_Running); end
    idle_ticks(30);
    drain_check("pause");
    bus.i_Pause = 1'b0;
    cyc();
    n_vec++;
    if (bus.o_Running !== 1'b1) begin n_err++; $display("FAIL resume_running: actual %b, required 1", bus.o_Running); end
    tick(1'b0, 2'b00);
    tick(1'b0, 2'b00);
    tick(1'b1, 2'b00);
    drain_check("resume");
  endtask

  task automatic test_stop();
    strobes(1, 38);
    drain_check("to_step7");
    n_vec++;
    if (bus.o_PhaseState !== 2'b10) begin n_err++; $display("FAIL pre_stop_phase: actual %b, required 10", bus.o_PhaseState); end
    idle_ticks(3);
    bus.i_Stop = 1'b1;
    cyc();
    bus.i_Stop = 1'b0;
    n_vec++;
    if (bus.o_Running !== 1'b0 || bus.o_PhaseState !== 2'b00) begin
      n_err++;
      $display("FAIL stop_state: actual running=%b phase=%b, required 0/00", bus.o_Running, bus.o_PhaseState);
    end
    idle_ticks(10);
    pulse_start();
    strobes(0, 16);
    drain_check("restart");
    n_vec++;
    if (bus.o_PhaseState !== 2'b01) begin n_err++; $display("FAIL restart_phase: actual %b, required 01", bus.o_PhaseState); end
  endtask

  task automatic test_stop_vs_tick();
    idle_ticks(7);
    bus.i_FrameTick = 1'b1;
    bus.i_Stop      = 1'b1;
    cyc();
    bus.i_FrameTick = 1'b0;
    bus.i_Stop      = 1'b0;
    cyc();
    drain_check("stop_tick");
    n_vec++;
    if (bus.o_Running !== 1'b0 || bus.o_PhaseState !== 2'b00) begin
      n_err++;
      $display("FAIL stop_tick_state: actual running=%b phase=%b, required 0/00", bus.o_Running, bus.o_PhaseState);
    end
  endtask

  task automatic test_start_with_pause();
    bus.i_Pause = 1'b1;
    pulse_start();
    n_vec++;
    if (bus.o_Running !== 1'b0) begin n_err++; $display("FAIL start_pause_running: actual %b, required 0", bus.o_Running); end
    idle_ticks(10);
    bus.i_Pause = 1'b0;
    cyc();
    n_vec++;
    if (bus.o_Running !== 1'b1) begin n_err++; $display("FAIL start_pause_resume: actual %b, required 1", bus.o_Running); end
    strobes(0, 1);
    drain_check("start_pause");
  endtask

  task automatic test_reset_mid();
    strobes(1, 16);
    idle_ticks(3);
    n_vec++;
    if (bus.o_PhaseState !== 2'b01) begin n_err++; $display("FAIL pre_reset_phase: actual %b, required 01", bus.o_PhaseState); end
    rst = 1'b1;
    cyc();
    n_vec++;
    if (bus.o_PhaseState !== 2'b00 || bus.o_Running !== 1'b0 || bus.o_MoveStrobe !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset: actual phase=%b running=%b strobe=%b, required 00/0/0",
               bus.o_PhaseState, bus.o_Running, bus.o_MoveStrobe);
    end
    rst = 1'b0;
    idle_ticks(10);
    drain_check("post_reset");
  endtask

`ifdef SPEEDUP_EN
  task automatic test_speedup();
    bus.i_AliveCount = 6'd8;
    pulse_start();
    for (int k = 0; k < 4; k++) begin
      for (int t = 1; t <= 4; t++) tick(t == 4, 2'b00);
    end
    drain_check("fast");
    bus.i_AliveCount = 6'd9;
    for (int t = 1; t <= 8; t++) tick(t == 8, 2'b00);
    drain_check("slow");
    idle_ticks(5);
    bus.i_AliveCount = 6'd8;
    tick(1'b1, 2'b00);
    drain_check("switch");
    bus.i_AliveCount = 6'd40;
  endtask
`endif

  initial begin
    rst              = 1'b1;
    bus.i_FrameTick  = 1'b0;
    bus.i_Start      = 1'b0;
    bus.i_Pause      = 1'b0;
    bus.i_Stop       = 1'b0;
    bus.i_AliveCount = 6'd40;

    test_reset();
    test_idle_ticks();
    test_run();
    test_phase_advance();
    test_pause();
    test_stop();
    test_stop_vs_tick();
    test_start_with_pause();
    test_reset_mid();
`ifdef SPEEDUP_EN
    test_speedup();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
